// File: rtl/mem_pkg.sv
// Shared encodings for the unified memory port arbiter and its load/store formatter.
package mem_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_lsu_format.sv
// Combinational byte-lane formatting: store enables/replication, misalign detect,
// and load extract with sign/zero extension.
module lsu_format
    import mem_pkg::*;
(
    input  logic [1:0]      st_off,
    input  logic [1:0]      st_size,
    input  logic [XLEN-1:0] st_wdata,
    output logic [BE_W-1:0] st_be,
    output logic [XLEN-1:0] st_wdata_rep,
    output logic            misalign,
    input  logic [1:0]      ld_off,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] ld_shift;

    always_comb begin
        st_be        = '1;
        st_wdata_rep = st_wdata;
        misalign     = 1'b0;
        case (st_size)
            SZ_B: begin
                st_be        = BE_W'(1) << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_be        = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep = {2{st_wdata[15:0]}};
                misalign     = st_off[0];
            end
            default: misalign = |st_off;
        endcase
    end

    always_comb begin
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_shift[7:0]}
                                           : {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_shift[15:0]}
                                           : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data path,
// one req/gnt/rvalid access outstanding at a time.
//
//   state    | meaning
//   IDLE     | arbitrate; capture winner or reject misaligned data access
//   WAIT_GNT | mem_req high from capture registers until mem_gnt
//   WAIT_RSP | waiting for mem_rvalid; returns valid to the owner
module mem_port_arbiter
    import mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [1:0]      d_size,
    input  logic            d_unsigned,
    output logic            d_valid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_misalign,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall
);

    state_e          state;
    owner_e          owner;
    owner_e          last;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [BE_W-1:0] cap_be;
    logic [1:0]      cap_size;
    logic            cap_we;
    logic            cap_uns;

    logic [BE_W-1:0] st_be;
    logic [XLEN-1:0] st_wdata_rep;
    logic            d_mis;
    logic [XLEN-1:0] ld_data;

    logic pick_d, pick_if, reject, rsp;

    lsu_format u_fmt (
        .st_off       (d_addr[1:0]),
        .st_size      (d_size),
        .st_wdata     (d_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata_rep),
        .misalign     (d_mis),
        .ld_off       (cap_addr[1:0]),
        .ld_size      (cap_size),
        .ld_unsigned  (cap_uns),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    // On a tie the side that was not served last wins.
    assign pick_d  = d_req & (~if_req | (last == OWN_IF));
    assign pick_if = if_req & ~pick_d;
    assign reject  = (state == IDLE) & pick_d & d_mis;
    assign rsp     = (state == WAIT_RSP) & mem_rvalid;

    assign if_valid   = rsp & (owner == OWN_IF);
    assign if_rdata   = if_valid ? mem_rdata : '0;
    assign d_valid    = (rsp & (owner == OWN_D)) | reject;
    assign d_misalign = reject;
    assign d_rdata    = (rsp & (owner == OWN_D) & ~cap_we) ? ld_data : '0;

    assign mem_req   = (state == WAIT_GNT);
    assign mem_we    = cap_we;
    assign mem_addr  = {cap_addr[XLEN-1:2], 2'b00};
    assign mem_be    = cap_be;
    assign mem_wdata = cap_wdata;

    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            last      <= OWN_D;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            cap_size  <= SZ_B;
            cap_we    <= 1'b0;
            cap_uns   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_if) begin
                        owner     <= OWN_IF;
                        cap_addr  <= if_addr;
                        cap_wdata <= '0;
                        cap_be    <= '1;
                        cap_size  <= SZ_W;
                        cap_we    <= 1'b0;
                        cap_uns   <= 1'b0;
                        state     <= WAIT_GNT;
                    end else if (pick_d) begin
                        if (d_mis) begin
                            last <= OWN_D;
                        end else begin
                            owner     <= OWN_D;
                            cap_addr  <= d_addr;
                            cap_wdata <= st_wdata_rep;
                            cap_be    <= st_be;
                            cap_size  <= d_size;
                            cap_we    <= d_we;
                            cap_uns   <= d_unsigned;
                            state     <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (mem_gnt) state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (mem_rvalid) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req = 1'b0;
    logic [XLEN-1:0] if_addr = '0;
    logic            if_valid;
    logic [XLEN-1:0] if_rdata;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [XLEN-1:0] d_addr = '0;
    logic [XLEN-1:0] d_wdata = '0;
    logic [1:0]      d_size = 2'b00;
    logic            d_unsigned = 1'b0;
    logic            d_valid;
    logic [XLEN-1:0] d_rdata;
    logic            d_misalign;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            stall;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_valid   (if_valid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_valid    (d_valid),
        .d_rdata    (d_rdata),
        .d_misalign (d_misalign),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall      (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        if_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One complete data access with gnt in cycle 1 and rvalid in cycle 2.
    task automatic d_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] size, input logic uns,
                            input logic [31:0] rd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rd);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_size = size; d_unsigned = uns;
        settle();
        chk({tag, "_accept_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_accept_stall"}, {31'b0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, we});
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
        chk({tag, "_wdata"}, mem_wdata, exp_wd);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
        settle();
        chk({tag, "_valid"}, {30'b0, d_valid, d_misalign}, 32'd2);
        chk({tag, "_rdata"}, d_rdata, exp_rd);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0; d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        do_reset();
        settle();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_valids", {30'b0, if_valid, d_valid}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        // Basic fetch at minimum latency
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        settle();
        chk("f_c0_stall", {31'b0, stall}, 32'd1);
        chk("f_c0_req", {31'b0, mem_req}, 32'd0);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("f_c1_req", {31'b0, mem_req}, 32'd1);
        chk("f_c1_addr", mem_addr, 32'h100);
        chk("f_c1_be", {28'b0, mem_be}, 32'hF);
        chk("f_c1_we", {31'b0, mem_we}, 32'd0);
        chk("f_c1_stall", {31'b0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A00093;
        settle();
        chk("f_c2_valid", {31'b0, if_valid}, 32'd1);
        chk("f_c2_rdata", if_rdata, 32'h00A00093);
        chk("f_c2_stall", {31'b0, stall}, 32'd0);
        chk("f_c2_req", {31'b0, mem_req}, 32'd0);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b0;
        settle();
        chk("f_c3_valid", {31'b0, if_valid}, 32'd0);
        chk("f_c3_stall", {31'b0, stall}, 32'd0);

        // Tie handling from reset: IF, then data, then IF again on the next tie
        do_reset();
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_size = SZ_W; d_unsigned = 1'b0;
        settle();
        chk("tie1_stall", {31'b0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("tie1_addr_if", mem_addr, 32'h400);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        settle();
        chk("tie1_valids", {30'b0, if_valid, d_valid}, 32'd2);
        chk("tie1_stall_d", {31'b0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b0; if_addr = 32'h404;
        settle();
        chk("tie_gap_req", {31'b0, mem_req}, 32'd0);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("tie2_addr_d", mem_addr, 32'h500);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
        settle();
        chk("tie2_valids", {30'b0, if_valid, d_valid}, 32'd1);
        chk("tie2_rdata", d_rdata, 32'h22222222);
        tick();
        mem_rvalid = 1'b0; d_addr = 32'h504;
        settle();
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("tie3_addr_if", mem_addr, 32'h404);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33333333;
        settle();
        chk("tie3_if_rdata", if_rdata, 32'h33333333);
        tick();
        mem_rvalid = 1'b0; if_req = 1'b0;
        settle();
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("tie4_addr_d", mem_addr, 32'h504);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h44444444;
        settle();
        chk("tie4_d_rdata", d_rdata, 32'h44444444);
        tick();
        mem_rvalid = 1'b0; d_req = 1'b0;

        // Stores and loads
        d_access("sb", 1'b1, 32'h203, 32'h000000AB, SZ_B, 1'b0, 32'h0,
                 32'h200, 4'b1000, 32'hABABABAB, 32'h0);
        d_access("sh", 1'b1, 32'h202, 32'h00001234, SZ_H, 1'b0, 32'h0,
                 32'h200, 4'b1100, 32'h12341234, 32'h0);
        d_access("sw", 1'b1, 32'h20C, 32'hCAFEF00D, SZ_W, 1'b0, 32'h0,
                 32'h20C, 4'b1111, 32'hCAFEF00D, 32'h0);
        d_access("lb", 1'b0, 32'h202, 32'h0, SZ_B, 1'b0, 32'h0080FF00,
                 32'h200, 4'b0100, 32'h0, 32'hFFFFFF80);
        d_access("lbu", 1'b0, 32'h201, 32'h0, SZ_B, 1'b1, 32'h0080FF00,
                 32'h200, 4'b0010, 32'h0, 32'h000000FF);
        d_access("lhu", 1'b0, 32'h202, 32'h0, SZ_H, 1'b1, 32'h0080FF00,
                 32'h200, 4'b1100, 32'h0, 32'h00000080);
        d_access("lh", 1'b0, 32'h200, 32'h0, SZ_H, 1'b0, 32'h12348001,
                 32'h200, 4'b0011, 32'h0, 32'hFFFF8001);
        d_access("lw", 1'b0, 32'h200, 32'h0, SZ_W, 1'b0, 32'h0080FF00,
                 32'h200, 4'b1111, 32'h0, 32'h0080FF00);

        // Misaligned accesses are rejected in the accept cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h201; d_size = SZ_W;
        settle();
        chk("mis_w_flags", {30'b0, d_valid, d_misalign}, 32'd3);
        chk("mis_w_rdata", d_rdata, 32'h0);
        chk("mis_w_req", {31'b0, mem_req}, 32'd0);
        chk("mis_w_stall", {31'b0, stall}, 32'd0);
        tick();
        d_addr = 32'h203; d_size = SZ_H; d_we = 1'b1; d_wdata = 32'h5555;
        settle();
        chk("mis_h_flags", {30'b0, d_valid, d_misalign}, 32'd3);
        chk("mis_h_req", {31'b0, mem_req}, 32'd0);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        settle();
        chk("mis_after_req", {31'b0, mem_req}, 32'd0);
        chk("mis_after_valid", {31'b0, d_valid}, 32'd0);

        // Grant held off for 5 cycles, then reset while waiting for the response
        tick();
        if_req = 1'b1; if_addr = 32'h300;
        settle();
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("hold_req", {31'b0, mem_req}, 32'd1);
            chk("hold_addr", mem_addr, 32'h300);
            chk("hold_be", {28'b0, mem_be}, 32'hF);
            tick();
        end
        mem_gnt = 1'b1;
        settle();
        chk("hold_gnt_req", {31'b0, mem_req}, 32'd1);
        tick();
        mem_gnt = 1'b0;
        settle();
        chk("rsp_wait_req", {31'b0, mem_req}, 32'd0);
        chk("rsp_wait_valid", {31'b0, if_valid}, 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_be", {28'b0, mem_be}, 32'h0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        settle();
        chk("late_rv_idle", {30'b0, if_valid, d_valid}, 32'd0);
        tick();
        settle();
        chk("late_rv_gnt_valid", {31'b0, if_valid}, 32'd0);
        chk("rearb_req", {31'b0, mem_req}, 32'd1);
        chk("rearb_addr", mem_addr, 32'h300);
        tick();
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        settle();
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        settle();
        chk("rearb_valid", {31'b0, if_valid}, 32'd1);
        chk("rearb_rdata", if_rdata, 32'h0BADF00D);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b0;
        settle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
